key_entry_collector: RTL and testbench
======================================

Name: key_entry_collector

Overview:
- Upstream stage of the digital lock state machine.
- Turns the four raw board push-buttons into debounced, single-shot key presses.
- Assembles DIGITS presses into one CODE_LENGTH-bit entry and strobes it to the lock for comparison.
- Discards partial entries after an inactivity timeout.

Parameters:
DIGITS, 4, number of digits per entry
CODE_LENGTH, 4*DIGITS, bits in an assembled entry (4 bits per digit)
COUNTER_WIDTH, $clog2(DIGITS), width base for digit counter
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a key level is accepted (1 ms at 50 MHz)
TIMEOUT_CYCLES, 250000000, idle cycles after last accepted digit before a partial entry is discarded (5 s)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
key  in  4  raw push-buttons, active-low (0 = pressed), asynchronous to clock
key_pressed  out  1  one-cycle pulse per accepted press
key_digit  out  4  digit of last accepted press (key index zero-extended), valid with key_pressed, held after
digit_count  out  COUNTER_WIDTH+1  digits collected in the current entry, 0..DIGITS-1
entry_busy  out  1  high while a partial entry exists
entry_valid  out  1  one-cycle pulse: entry_code holds a complete new entry
entry_code  out  CODE_LENGTH  last completed entry, first digit in MS nibble; held until the next completion
entry_timeout  out  1  one-cycle pulse when a partial entry is discarded

Behaviour:
- Reset (reset=0, async):
  - sync and debounced key registers = 4'b1111 (released); debounce and idle counters = 0; state = IDLE.
  - All outputs 0 (entry_code = 0, key_digit = 0).
  - Reset mid-entry drops the partial entry; no entry_valid is produced.
- Synchroniser: 2 FF per key.
- Debounce, per key:
  - counter increments while synced level != debounced level; clears when they match.
  - At DEBOUNCE_CYCLES the debounced level takes the synced level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: debounced level falls 1->0. Release events are ignored.
- Acceptance:
  - A press is accepted only if exactly one key has a press event that cycle and no other key is debounced-pressed.
  - Otherwise it is silently ignored; holding one key and pressing a second yields nothing.
- key_pressed and key_digit are registered one cycle after the debounced change.
  - Raw edge to key_pressed is DEBOUNCE_CYCLES+3 edges for a clean input.
- State machine:
  - IDLE: on an accepted press, shift the digit into the collect register, digit_count=1, go to COLLECT. If DIGITS==1, go straight to completion.
  - COLLECT: each accepted press shifts the collect register left by 4, inserts the digit in the LS nibble, and increments digit_count.
    - On the DIGITS-th press: entry_code <= assembled value, entry_valid pulses in the same cycle as that key_pressed, digit_count <= 0, go to IDLE.
  - COLLECT timeout: the idle counter clears on each accepted press and increments otherwise. At TIMEOUT_CYCLES: entry_timeout pulses, collect register and digit_count clear, go to IDLE. entry_code is unchanged.
  - A press accepted in the same cycle as the timeout is lost; timeout wins.
- entry_busy = (state == COLLECT).
- Idle counter saturates; it never wraps.
- Digit counter width is COUNTER_WIDTH+1, so DIGITS that is a power of two does not overflow.

Decomposition:
- Shared package lock_pkg:
  - state encodings IDLE/COLLECT;
  - DIGIT_WIDTH=4;
  - KEY_COUNT=4;
  - default DEBOUNCE_CYCLES/TIMEOUT_CYCLES.
- Sub-module key_debouncer: one instance per key, containing the 2-FF sync, counter and debounced level. It outputs the debounced level and a press-event pulse.
- The top level holds the acceptance logic, collect FSM and timeout.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, DIGITS=4):
- Clean presses: key[2], key[0], key[3], key[1], each held 10 cycles with 10 cycles gap.
  - Expect 4 key_pressed pulses with key_digit 2,0,3,1.
  - entry_valid pulses once with entry_code=16'h2031.
  - digit_count runs 1,2,3,0.
- Bounce:
  - key[1] toggling every 2 cycles for 20 cycles, then held low -> exactly one key_pressed, key_digit=1.
  - A 3-cycle low glitch -> no pulse.
- Two keys: key[0] held, then key[3] pressed -> no key_pressed for key[3]. Simultaneous press of key[1] and key[2] -> nothing accepted.
- Timeout:
  - Two digits entered, then 100 idle cycles -> entry_timeout pulse, digit_count=0, entry_busy=0, entry_code unchanged.
  - A following 4-digit entry completes normally.
- Reset mid-entry: after 3 digits assert reset=0 for 2 cycles -> all outputs 0. A subsequent 4-digit entry 3,3,3,3 gives entry_code=16'h3333.
- Latency: a clean key[0] fall sampled at edge k -> key_pressed high exactly at edge k+DEBOUNCE_CYCLES+3, width one cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock front end: key/digit widths, collector
// states and default timing for a 50 MHz clock.
package lock_pkg;

  localparam int DIGIT_WIDTH             = 4;
  localparam int KEY_COUNT               = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 250000000;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-FF synchroniser, stability counter and debounced level.
// press_o pulses for one cycle in the cycle after the debounced level falls.
module key_debouncer
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == LIMIT) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      deb_q  <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      deb_q  <= deb_d;
      prev_q <= deb_q;
      cnt_q  <= cnt_d;
    end
  end

  // prev_q lags deb_q by one cycle, so the fall is seen after it has settled
  assign level_o = deb_q;
  assign press_o = prev_q & ~deb_q;

endmodule

// File: rtl/key_entry_collector.sv
// Debounced keypad front end: accepts single-key presses and assembles
// DIGITS of them into one entry for the lock, discarding stale partial entries.
//
// state   | meaning
// IDLE    | no partial entry held, waiting for the first digit
// COLLECT | 1..DIGITS-1 digits held, idle timer running
module key_entry_collector
  import lock_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int CODE_LENGTH     = 4 * DIGITS,
  parameter int COUNTER_WIDTH   = $clog2(DIGITS),
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [KEY_COUNT-1:0]   key,
  output logic                   key_pressed,
  output logic [DIGIT_WIDTH-1:0] key_digit,
  output logic [COUNTER_WIDTH:0] digit_count,
  output logic                   entry_busy,
  output logic                   entry_valid,
  output logic [CODE_LENGTH-1:0] entry_code,
  output logic                   entry_timeout
);

  localparam int NW = COUNTER_WIDTH + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NW-1:0] DIGITS_C  = NW'(DIGITS);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT_CYCLES);

  logic [KEY_COUNT-1:0] level, press;

  for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .key_i  (key[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  logic                   accept;
  logic [DIGIT_WIDTH-1:0] acc_digit;

  // Exactly one fresh press, and no other key already held down
  always_comb begin
    accept    = 1'b0;
    acc_digit = '0;
    if ((press != '0) && ((press & (press - KEY_COUNT'(1))) == '0) &&
        ((~level & ~press) == '0)) begin
      accept = 1'b1;
    end
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (press[i]) acc_digit = DIGIT_WIDTH'(i);
    end
  end

  state_e                 state_q, state_d;
  logic [CODE_LENGTH-1:0] collect_q, collect_d;
  logic [NW-1:0]          count_q, count_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic [CODE_LENGTH-1:0] code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   pressed_q;
  logic [DIGIT_WIDTH-1:0] digit_q, digit_d;

  logic [CODE_LENGTH-1:0] assembled;
  logic [NW-1:0]          next_count;
  logic                   complete;

  // count_q is 0 in IDLE, so one completion test covers DIGITS == 1 as well
  assign assembled  = (collect_q << DIGIT_WIDTH) | CODE_LENGTH'(acc_digit);
  assign next_count = count_q + NW'(1);
  assign complete   = (next_count == DIGITS_C);

  always_comb begin
    state_d   = state_q;
    collect_d = collect_q;
    count_d   = count_q;
    idle_d    = idle_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    digit_d   = accept ? acc_digit : digit_q;

    if (state_q == COLLECT && idle_q == TIMEOUT_C) begin
      timeout_d = 1'b1;
      collect_d = '0;
      count_d   = '0;
      idle_d    = '0;
      state_d   = IDLE;
    end else if (accept) begin
      idle_d = '0;
      if (complete) begin
        code_d    = assembled;
        valid_d   = 1'b1;
        collect_d = '0;
        count_d   = '0;
        state_d   = IDLE;
      end else begin
        collect_d = assembled;
        count_d   = next_count;
        state_d   = COLLECT;
      end
    end else if (state_q == COLLECT) begin
      if (idle_q != TIMEOUT_C) idle_d = idle_q + IW'(1);
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      collect_q <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      pressed_q <= 1'b0;
      digit_q   <= '0;
    end else begin
      state_q   <= state_d;
      collect_q <= collect_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      pressed_q <= accept;
      digit_q   <= digit_d;
    end
  end

  assign key_pressed   = pressed_q;
  assign key_digit     = digit_q;
  assign digit_count   = count_q;
  assign entry_busy    = (state_q == COLLECT);
  assign entry_valid   = valid_q;
  assign entry_code    = code_q;
  assign entry_timeout = timeout_q;

endmodule

// File: tb/tb_key_entry_collector.sv
// Directed bench for key_entry_collector with short debounce/timeout values.
module tb_key_entry_collector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key   = 4'hF;
  logic        key_pressed;
  logic [3:0]  key_digit;
  logic [2:0]  digit_count;
  logic        entry_busy;
  logic        entry_valid;
  logic [15:0] entry_code;
  logic        entry_timeout;

  int tests    = 0;
  int failures = 0;

  int presses[$];
  int counts[$];
  int valids   = 0;
  int timeouts = 0;

  key_entry_collector #(
    .DIGITS         (4),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .key_pressed  (key_pressed),
    .key_digit    (key_digit),
    .digit_count  (digit_count),
    .entry_busy   (entry_busy),
    .entry_valid  (entry_valid),
    .entry_code   (entry_code),
    .entry_timeout(entry_timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (key_pressed) begin
        presses.push_back(int'(key_digit));
        counts.push_back(int'(digit_count));
      end
      if (entry_valid) valids++;
      if (entry_timeout) timeouts++;
    end
  end

  task automatic check(string tag, int obs, int exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(int idx);
    @(negedge clock);
    key[idx] = 1'b0;
    repeat (10) @(negedge clock);
    key[idx] = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic check_seq(string tag, int base, int n, logic [15:0] digits, logic [15:0] cnts);
    check({tag, "_npress"}, presses.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < presses.size()) begin
        check($sformatf("%s_digit%0d", tag, i), presses[base + i],
              int'((digits >> (4 * (n - 1 - i))) & 16'hF));
        check($sformatf("%s_count%0d", tag, i), counts[base + i],
              int'((cnts >> (4 * (n - 1 - i))) & 16'hF));
      end
    end
  endtask

  task automatic wait_timeout(string tag);
    int start;
    bit seen;
    start = timeouts;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (timeouts != start) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_pressed"}, int'(key_pressed), 0);
    check({tag, "_digit"},   int'(key_digit), 0);
    check({tag, "_count"},   int'(digit_count), 0);
    check({tag, "_busy"},    int'(entry_busy), 0);
    check({tag, "_valid"},   int'(entry_valid), 0);
    check({tag, "_code"},    int'(entry_code), 0);
    check({tag, "_timeout"}, int'(entry_timeout), 0);
  endtask

  initial begin
    int p0, v0, first, highs;

    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // clean four-digit entry
    p0 = presses.size(); v0 = valids;
    press_key(2); press_key(0); press_key(3); press_key(1);
    check_seq("clean", p0, 4, 16'h2031, 16'h1230);
    check("clean_valids", valids - v0, 1);
    check("clean_code", int'(entry_code), 'h2031);
    check("clean_busy", int'(entry_busy), 0);

    // bouncing key[1], then a short glitch on key[2]
    p0 = presses.size();
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clock);
    end
    key[1] = 1'b0;
    repeat (10) @(negedge clock);
    key[1] = 1'b1;
    repeat (10) @(negedge clock);
    key[2] = 1'b0;
    repeat (3) @(negedge clock);
    key[2] = 1'b1;
    repeat (10) @(negedge clock);
    check_seq("bounce", p0, 1, 16'h1, 16'h1);
    check("bounce_busy", int'(entry_busy), 1);
    wait_timeout("bounce_timeout");

    // second key while one is held; two keys together
    p0 = presses.size();
    key[0] = 1'b0; repeat (10) @(negedge clock);
    key[3] = 1'b0; repeat (10) @(negedge clock);
    key[3] = 1'b1; repeat (10) @(negedge clock);
    key[0] = 1'b1; repeat (10) @(negedge clock);
    key[2:1] = 2'b00; repeat (10) @(negedge clock);
    key[2:1] = 2'b11; repeat (10) @(negedge clock);
    check_seq("two_keys", p0, 1, 16'h0, 16'h1);
    wait_timeout("two_keys_timeout");

    // partial entry times out, then a full entry completes
    p0 = presses.size();
    press_key(1); press_key(2);
    check_seq("partial", p0, 2, 16'h12, 16'h12);
    check("partial_busy", int'(entry_busy), 1);
    wait_timeout("idle_timeout");
    check("to_count", int'(digit_count), 0);
    check("to_busy", int'(entry_busy), 0);
    check("to_code", int'(entry_code), 'h2031);
    p0 = presses.size(); v0 = valids;
    press_key(3); press_key(2); press_key(1); press_key(0);
    check_seq("after_to", p0, 4, 16'h3210, 16'h1230);
    check("after_to_valids", valids - v0, 1);
    check("after_to_code", int'(entry_code), 'h3210);

    // reset mid-entry
    press_key(1); press_key(2); press_key(3);
    check("mid_count", int'(digit_count), 3);
    reset = 1'b0;
    @(negedge clock);
    check_zero("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    p0 = presses.size(); v0 = valids;
    press_key(3); press_key(3); press_key(3); press_key(3);
    check_seq("post_reset", p0, 4, 16'h3333, 16'h1230);
    check("post_reset_valids", valids - v0, 1);
    check("post_reset_code", int'(entry_code), 'h3333);

    // latency: fall sampled at edge n=1, pulse expected at edge n=1+4+3
    first = 0; highs = 0;
    @(negedge clock);
    key[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
      if (key_pressed) begin
        if (first == 0) first = n;
        highs++;
      end
    end
    key[0] = 1'b1;
    repeat (10) @(negedge clock);
    check("latency_edge", first, 8);
    check("latency_width", highs, 1);
    check("latency_count", int'(digit_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
